ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 32-bit data/instruction RAM between two requesters: port 0 = instruction fetch
//  (IF), port 1 = load/store unit (LS). Arbitrates, drives RAM address/data/write_enable/read_enable,
//  waits out the RAM's 1-cycle registered read and returns data with a one-cycle ack pulse.
//  Sits between the CPU control unit and the RAM instance.
// PARAMETERS
//  ADDR_W   8    RAM address width
//  DATA_W   32   data width
// PORTS
//  clk          in   1       system clock; all state on posedge
//  clear_n      in   1       asynchronous, active-low reset
//  req0/req1    in   1       request, IF / LS; hold high until ack
//  we0/we1      in   1       1 = write, 0 = read (IF drives 0)
//  addr0/addr1  in   ADDR_W  word address
//  wdata0/1     in   DATA_W  write data
//  ack0/ack1    out  1       one-cycle completion pulse
//  rdata0/1     out  DATA_W  read data, valid while ackN=1
//  ram_addr     out  ADDR_W  to RAM address
//  ram_wdata    out  DATA_W  to RAM_data_in
//  ram_we       out  1       to RAM write_enable
//  ram_re       out  1       to RAM read_enable
//  ram_rdata    in   DATA_W  from RAM_data_out
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE; ram_we=ram_re=0, ram_addr=0, ram_wdata=0, ack*=0, rdata*=0, last_gnt=0.
//  FSM states: IDLE -> ACCESS -> RESP -> IDLE. No other transitions.
//  - IDLE: if any req: pick winner; on this edge register ram_addr/ram_wdata/ram_we=weN/ram_re=~weN,
//    latch gnt index; -> ACCESS. If none: stay; strobes stay 0.
//  - ACCESS: the RAM performs the access on this edge; ram_we/ram_re cleared on this edge; -> RESP.
//  - RESP: ackN=1 for the granted port only; rdataN = ram_rdata for a read, 0 for a write;
//    other port's rdata = 0; -> IDLE.
//  Latency: req sampled at edge E0 -> ack high for the cycle after E1 (2 cycles); max 1 op per 3 cycles.
//  Exactly one of ram_we/ram_re is high, only during ACCESS; never both.
//  Arbitration: fixed priority, LS (port 1) over IF (port 0) (see CONFIGURATION).
//  Request fields are latched at grant; changes or req drop afterwards have no effect; the access
//  completes and ack still pulses. A req still high in IDLE after its ack is a new request.
//  Write followed by read to same address returns the new data (strict ordering, no buffering).
//  Address wraps naturally at 2^ADDR_W; no range check.
//  Reset asserted mid-operation: strobes drop immediately, ack not issued, transaction lost.
// CONFIGURATION
//  RAM_ARB_RR_EN defined: round-robin; on simultaneous req the port != last_gnt wins; last_gnt
//    updated at each grant. Worst-case wait for a continuously requesting port = one other access.
//  Not defined: fixed priority LS>IF; IF may starve under back-to-back LS; last_gnt unused.
// STRUCTURE
//  Package ram_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), port indices
//    PORT_IF=1'b0, PORT_LS=1'b1, widths ADDR_W/DATA_W defaults.
//  Sub-module ram_arb_pick: combinational winner select (req0, req1, last_gnt) -> gnt_valid, gnt_idx;
//    contains the RAM_ARB_RR_EN conditional. FSM, strobes and ack/rdata muxing stay in top.
// TESTING (bench uses the RAM model with mem[84]=0x97, mem[52]=0x25)
//  1 IF read: req0=1,we0=0,addr0=84 -> ram_re high 1 cycle, ack0 2 cycles later, rdata0=0x00000097.
//  2 LS write then read: write addr1=52 wdata1=0xDEADBEEF -> ack1, rdata1=0; read 52 -> 0xDEADBEEF.
//  3 Simultaneous req0=req1=1 (read 84 / read 52): default -> LS acked first (0x25) then IF (0x97);
//    RR_EN with last_gnt=1 -> IF first.
//  4 LS held high continuously 6 ops with IF also high: default -> ack0 never; RR_EN -> ack0/ack1 alternate.
//  5 clear_n low during ACCESS -> strobes 0 same cycle, no ack, busy=0; after release req0 read 84 -> 0x97.
//  6 Protocol checks every cycle: ram_we&ram_re never 1; ack0&ack1 never 1; ack only in RESP.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Optional round-robin arbitration is enabled with the RAM_ARB_RR_EN macro.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // FSM encoding; RESP is the only state in which an ack may be raised.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef struct packed {
        logic [1:0] state;
        logic       gnt;
        logic       last_gnt;
    } arb_dbg_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the RAM arbiter.
// RAM_ARB_RR_EN selects round-robin; otherwise LS has fixed priority over IF.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    assign gnt_valid_o = req0_i | req1_i;

`ifdef RAM_ARB_RR_EN
    // On a tie the port that was not served last wins.
    always_comb begin
        gnt_idx_o = PORT_IF;
        if (req0_i && req1_i) begin
            gnt_idx_o = ~last_gnt_i;
        end else if (req1_i) begin
            gnt_idx_o = PORT_LS;
        end
    end
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt_i;

    always_comb begin
        gnt_idx_o = PORT_IF;
        if (req1_i) begin
            gnt_idx_o = PORT_LS;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (port 0) and load/store (port 1).
// Build with RAM_ARB_RR_EN for round-robin arbitration instead of fixed LS priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output arb_dbg_t          dbg_o
);

    // Handshake: a requester raises reqN with its fields and holds it until ackN.
    // Fields are captured at grant, so later changes or a dropped req are ignored;
    // ackN is a single-cycle pulse and rdataN is valid only while ackN is high.

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              last_gnt_q, last_gnt_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic gnt_valid;
    logic gnt_idx;

    ram_arb_pick u_pick (
        .req0_i      (req0),
        .req1_i      (req1),
        .last_gnt_i  (last_gnt_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        last_gnt_d  = last_gnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    gnt_d      = gnt_idx;
                    last_gnt_d = gnt_idx;
                    if (gnt_idx == PORT_LS) begin
                        we_d        = we1;
                        ram_addr_d  = addr1;
                        ram_wdata_d = wdata1;
                    end else begin
                        we_d        = we0;
                        ram_addr_d  = addr0;
                        ram_wdata_d = wdata0;
                    end
                    ram_we_d = we_d;
                    ram_re_d = ~we_d;
                    state_d  = ST_ACCESS;
                end
            end
            // The RAM samples the strobes on the edge leaving ACCESS.
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= PORT_IF;
            we_q        <= 1'b0;
            last_gnt_q  <= PORT_IF;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            last_gnt_q  <= last_gnt_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Read data arrives from the RAM's output register during RESP, so it is steered combinationally.
    assign ack0   = (state_q == ST_RESP) && (gnt_q == PORT_IF);
    assign ack1   = (state_q == ST_RESP) && (gnt_q == PORT_LS);
    assign rdata0 = (ack0 && !we_q) ? ram_rdata : '0;
    assign rdata1 = (ack1 && !we_q) ? ram_rdata : '0;

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign busy      = (state_q != ST_IDLE);

    assign dbg_o.state    = state_q;
    assign dbg_o.gnt      = gnt_q;
    assign dbg_o.last_gnt = last_gnt_q;

endmodule
